and_stim_gen: RTL and testbench

AND_STIM_GEN -- requirements
Module: and_stim_gen

---
 rtl/and_test_pkg.sv | 53 +++++
 rtl/and_stim_gen_if.sv | 26 ++
 rtl/dwell_timer.sv | 33 +++
 rtl/and_stim_gen.sv | 98 +++++++++
 tb/tb_and_stim_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/and_test_pkg.sv
// Shared types, sizes and stimulus tables for the i1/i2 stimulus generator.
package and_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_STEPS = 12;
  localparam int CNT_W     = 12;
  localparam int STEP_W    = 4;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  // Consecutive entries differ in exactly one bit, so the detector never sees both inputs toggle together.
  function automatic logic [1:0] pat_of(input logic [STEP_W-1:0] k);
    logic [1:0] p;
    case (k)
      4'd0:    p = 2'b00;
      4'd1:    p = 2'b01;
      4'd2:    p = 2'b11;
      4'd3:    p = 2'b10;
      4'd4:    p = 2'b00;
      4'd5:    p = 2'b01;
      4'd6:    p = 2'b11;
      4'd7:    p = 2'b10;
      4'd8:    p = 2'b00;
      4'd9:    p = 2'b10;
      4'd10:   p = 2'b11;
      4'd11:   p = 2'b10;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] dwell_of(input logic [STEP_W-1:0] k);
    logic [2:0] d;
    case (k)
      4'd4:    d = 3'd3;
      4'd6:    d = 3'd2;
      4'd7:    d = 3'd3;
      4'd8:    d = 3'd2;
      default: d = 3'd5;
    endcase
    return d;
  endfunction

  // Counter preload for step k: the step lasts load+1 cycles.
  function automatic logic [CNT_W-1:0] dwell_load(input logic [STEP_W-1:0] k, input int scale);
    return CNT_W'(int'(dwell_of(k)) * scale - 1);
  endfunction

endpackage

// File: rtl/and_stim_gen_if.sv
// Control and stimulus bundle between the generator and its consumer.
interface and_stim_gen_if;
  import and_test_pkg::*;

  // start is a level request sampled every cycle; it only takes effect in IDLE and needs no acknowledge
  // beyond busy rising. pause is a level hold applied only while busy is high.
  logic                start;
  logic                pause;
  logic                i1;
  logic                i2;
  logic [STEP_W-1:0]   step;
  logic                busy;
  logic                done;
  state_e              state;

  modport master (
    input  start, pause,
    output i1, i2, step, busy, done, state
  );

  modport slave (
    output start, pause,
    input  i1, i2, step, busy, done, state
  );

endinterface

// File: rtl/dwell_timer.sv
// Down-counter that times one step: load sets the count, en decrements it, expired flags zero.
module dwell_timer import and_test_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/and_stim_gen.sv
// Plays a fixed 12-step {i2,i1} sequence with per-step dwell times into the downstream sequence detector.
module and_stim_gen #(
  parameter int DWELL_SCALE = 1
) (
  input  logic           clk,
  input  logic           reset,
  and_stim_gen_if.master bus
);
  import and_test_pkg::*;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [1:0]        pat_q, pat_d;
  logic [STEP_W-1:0] step_nxt;

  logic              tmr_load;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              tmr_expired;

  assign step_nxt = step_q + STEP_W'(1);

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    pat_d        = pat_q;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = dwell_load(step_nxt, DWELL_SCALE);

    unique case (state_q)
      IDLE: begin
        step_d = '0;
        pat_d  = '0;
        if (bus.start) begin
          state_d      = RUN;
          pat_d        = pat_of(STEP_W'(0));
          tmr_load     = 1'b1;
          tmr_load_val = dwell_load(STEP_W'(0), DWELL_SCALE);
        end
      end
      RUN: begin
        // pause is checked first so a pause on the expiry cycle holds the step.
        if (!bus.pause) begin
          if (!tmr_expired) begin
            tmr_en = 1'b1;
          end else if (step_q != LAST_STEP) begin
            step_d   = step_nxt;
            pat_d    = pat_of(step_nxt);
            tmr_load = 1'b1;
          end else begin
            state_d = DONE;
            pat_d   = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
        pat_d   = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        pat_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      pat_q   <= pat_d;
    end
  end

  dwell_timer u_dwell_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  assign bus.i1    = pat_q[0];
  assign bus.i2    = pat_q[1];
  assign bus.step  = step_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.state = state_q;

endmodule

// File: tb/tb_and_stim_gen.sv
// Directed bench for and_stim_gen: full runs, pause, held start, mid-run reset and a scaled-dwell instance.
module tb_and_stim_gen;
  import and_test_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  and_stim_gen_if if_a ();
  and_stim_gen_if if_b ();

  and_stim_gen #(.DWELL_SCALE(1)) dut_a (.clk(clk), .reset(rst), .bus(if_a));
  and_stim_gen #(.DWELL_SCALE(3)) dut_b (.clk(clk), .reset(rst), .bus(if_b));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  int pat_tbl   [12] = '{0, 1, 3, 2, 0, 1, 3, 2, 0, 2, 3, 2};
  int dwell_tbl [12] = '{5, 5, 5, 5, 3, 5, 2, 3, 2, 5, 5, 5};

  // Hand-derived {i2,i1} at selected cycles of an unpaused DWELL_SCALE=1 run.
  int dir_cyc [24] = '{0, 4, 5, 9, 10, 14, 15, 19, 20, 22, 23, 27,
                       28, 29, 30, 32, 33, 34, 35, 39, 40, 44, 45, 49};
  int dir_pat [24] = '{0, 0, 1, 1, 3, 3, 2, 2, 0, 0, 1, 1,
                       3, 3, 2, 2, 0, 0, 2, 2, 3, 3, 2, 2};

  logic [1:0] rec_pat  [256];
  logic [3:0] rec_step [256];

  typedef struct packed {
    logic [1:0] pat;
    logic [3:0] step;
    logic       busy;
    logic       done;
    logic [1:0] st;
  } obs_t;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic s, input logic p);
    if (sel == 0) begin
      if_a.start = s;
      if_a.pause = p;
    end else begin
      if_b.start = s;
      if_b.pause = p;
    end
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.pat  = {if_a.i2, if_a.i1};
      o.step = if_a.step;
      o.busy = if_a.busy;
      o.done = if_a.done;
      o.st   = if_a.state;
    end else begin
      o.pat  = {if_b.i2, if_b.i1};
      o.step = if_b.step;
      o.busy = if_b.busy;
      o.done = if_b.done;
      o.st   = if_b.state;
    end
    return o;
  endfunction

  task automatic check_idle(input int sel, input string tag);
    obs_t o;
    o = get_obs(sel);
    check_val({tag, "_pat"},   o.pat,  0);
    check_val({tag, "_step"},  o.step, 0);
    check_val({tag, "_busy"},  o.busy, 0);
    check_val({tag, "_done"},  o.done, 0);
    check_val({tag, "_state"}, o.st,   IDLE);
  endtask

  // Starts a run from IDLE and follows it to the done pulse with a remaining-cycles model.
  // Cycle 0 is the first RUN cycle; pause is high during cycles p_lo..p_hi-1.
  task automatic run_seq(input int sel, input int scale, input int p_lo, input int p_hi,
                         input int exp_done, input logic hold_start);
    obs_t       o;
    int         c;
    int         m_step;
    int         m_left;
    int         prev_step;
    logic [1:0] prev_pat;
    logic [1:0] exp_v;
    logic       paused;

    drive(sel, 1'b1, 1'b0);
    tick();
    if (!hold_start) drive(sel, 1'b0, 1'b0);
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(2'(pat_tbl[k]));
    c         = 0;
    m_step    = 0;
    m_left    = dwell_tbl[0] * scale;
    prev_step = -1;
    prev_pat  = 2'b00;

    while (c < 400) begin
      o = get_obs(sel);
      if (o.done) break;
      if (c < 256) begin
        rec_pat[c]  = o.pat;
        rec_step[c] = o.step;
      end
      check_val("run_step", o.step, m_step);
      check_val("run_pat",  o.pat,  pat_tbl[m_step]);
      check_val("run_busy", o.busy, 1);
      if (int'(o.step) != prev_step) begin
        if (exp_q.size() == 0) begin
          check_val("det_extra_step", o.step, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check_val("det_pat", o.pat, exp_v);
        end
        if (prev_step >= 0) check_val("det_one_bit", $countones(o.pat ^ prev_pat), 1);
        prev_step = int'(o.step);
        prev_pat  = o.pat;
      end
      paused = (c >= p_lo) && (c < p_hi);
      drive(sel, hold_start, paused);
      tick();
      if (!paused) begin
        m_left--;
        if (m_left == 0 && m_step < 11) begin
          m_step++;
          m_left = dwell_tbl[m_step] * scale;
        end
      end
      c++;
    end

    check_val("done_cycle", c, exp_done);
    check_val("det_final",  exp_q.size(), 0);
    o = get_obs(sel);
    check_val("done_pulse", o.done, 1);
    check_val("done_busy",  o.busy, 0);
    check_val("done_step",  o.step, 11);
    check_val("done_pat",   o.pat,  0);
    drive(sel, hold_start, 1'b0);
    tick();
    o = get_obs(sel);
    check_val("post_done",  o.done, 0);
    check_val("post_state", o.st,   IDLE);
    check_val("post_busy",  o.busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    obs_t o;
    int   done_cnt;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    tick();
    tick();
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    rst = 1'b0;
    tick();
    check_idle(0, "idle_a");

    // Unpaused run plus the hand-derived waveform points.
    run_seq(0, 1, -1, -1, 50, 1'b0);
    for (int k = 0; k < 24; k++) check_val("dir_pat", rec_pat[dir_cyc[k]], dir_pat[k]);

    // Pause for 7 cycles inside step 4, spanning its expiry cycle.
    run_seq(0, 1, 21, 28, 57, 1'b0);
    check_val("pause_step29", rec_step[29], 4);
    check_val("pause_step30", rec_step[30], 5);

    // Reset wins over start in the same cycle.
    drive(0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0);
    check_idle(0, "rst_vs_start");

    // Reset in the middle of step 5.
    drive(0, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0);
    for (int k = 0; k < 23; k++) tick();
    o = get_obs(0);
    check_val("mid_step5", o.step, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(0, "rst_mid");
    done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      o = get_obs(0);
      if (o.done || o.busy) done_cnt++;
      tick();
    end
    check_val("rst_no_activity", done_cnt, 0);
    run_seq(0, 1, -1, -1, 50, 1'b0);

    // start held high: ignored during RUN/DONE, restarts from the IDLE cycle after DONE.
    run_seq(0, 1, -1, -1, 50, 1'b1);
    tick();
    o = get_obs(0);
    check_val("restart_busy", o.busy, 1);
    check_val("restart_step", o.step, 0);
    check_val("restart_pat",  o.pat,  0);
    drive(0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle(0, "hold_rst");

    // Scaled dwell instance.
    run_seq(1, 3, -1, -1, 150, 1'b0);
    check_val("scale_step14", rec_step[14], 0);
    check_val("scale_step15", rec_step[15], 1);
    check_idle(0, "a_quiet");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
